// File: rtl/short_mac_pkg.sv
// Shared types and constants for the short-pair multiply-accumulate engine.
package short_mac_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   localparam int SHORT_W = 16;
   localparam int PROD_W  = 32;

   // Each 32-bit slice of a RAM word carries one (a, b) short pair.
   function automatic int lanes(input int dataWidth);
      return dataWidth / 32;
   endfunction

endpackage

// File: rtl/short_mac_lane.sv
// One registered signed 16x16 multiplier lane; maps onto a single DSP block.
module short_mac_lane
   import short_mac_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_en,
   input  logic signed [SHORT_W-1:0] i_a,
   input  logic signed [SHORT_W-1:0] i_b,
   output logic signed [PROD_W-1:0]  o_prod
);

   logic signed [PROD_W-1:0] r_prod;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prod <= '0;
      end else if (i_en) begin
         r_prod <= PROD_W'(i_a) * PROD_W'(i_b);
      end
   end

   assign o_prod = r_prod;

endmodule

// File: rtl/short_mac_engine.sv
// Streams N words from RAM, multiplies each short pair in parallel lanes and accumulates a signed total.
// Define SHORT_MAC_SATURATE_EN for saturating accumulation with a sticky overflow flag; otherwise it wraps.
module short_mac_engine
   import short_mac_pkg::*;
#(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 2,
   parameter int ACC_WIDTH    = 40,
   parameter int READ_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [ADDR_WIDTH:0]         word_count,
   output logic [ADDR_WIDTH-1:0]       ram_addr,
   input  logic [DATA_WIDTH-1:0]       ram_q,
   output logic                        busy,
   output logic                        done,
   output logic signed [ACC_WIDTH-1:0] result,
   output logic                        overflow
);

   localparam int LANES = lanes(DATA_WIDTH);
   localparam int VLD_D = READ_LATENCY + 2;
   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                       r_state;
   logic [ADDR_WIDTH:0]          r_count;
   logic [ADDR_WIDTH-1:0]        r_addr;
   logic [VLD_D-1:0]             r_vld;
   logic                         r_busy;
   logic                         r_done;
   logic signed [ACC_WIDTH-1:0]  r_acc;

   logic [ADDR_WIDTH:0]          w_countClamped;
   logic                         w_lastAddr;
   logic                         w_issue;
   logic                         w_pipeEmpty;
   logic signed [PROD_W-1:0]     w_prod [LANES];
   logic signed [ACC_WIDTH-1:0]  w_laneSum;
   logic signed [ACC_WIDTH-1:0]  w_accNext;

   assign w_countClamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
   assign w_lastAddr     = ({1'b0, r_addr} == (r_count - (ADDR_WIDTH+1)'(1)));
   assign w_issue        = (r_state == ISSUE);
   // The final stage marks the accumulator as updated, so it does not hold the drain open.
   assign w_pipeEmpty    = ~|r_vld[READ_LATENCY:0];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      short_mac_lane u_lane (
         .clk    (clk),
         .reset  (reset),
         .i_en   (r_vld[READ_LATENCY-1]),
         .i_a    (ram_q[32*k +: SHORT_W]),
         .i_b    (ram_q[32*k+SHORT_W +: SHORT_W]),
         .o_prod (w_prod[k])
      );
   end

   always_comb begin
      w_laneSum = '0;
      for (int k = 0; k < LANES; k++) begin
         w_laneSum = w_laneSum + ACC_WIDTH'(w_prod[k]);
      end
   end

`ifdef SHORT_MAC_SATURATE_EN
   logic                        r_ovf;
   logic signed [ACC_WIDTH:0]   w_sumExt;
   logic                        w_addOvf;

   assign w_sumExt = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_laneSum);
   assign w_addOvf = w_sumExt[ACC_WIDTH] ^ w_sumExt[ACC_WIDTH-1];

   always_comb begin
      w_accNext = w_sumExt[ACC_WIDTH-1:0];
      if (w_addOvf) begin
         w_accNext = w_sumExt[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_ovf <= 1'b0;
      end else if (r_vld[READ_LATENCY] && w_addOvf) begin
         r_ovf <= 1'b1;
      end
   end

   assign overflow = r_ovf;
`else
   assign w_accNext = r_acc + w_laneSum;
   assign overflow  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_addr  <= '0;
         r_vld   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_acc   <= '0;
      end else begin
         r_vld  <= {r_vld[VLD_D-2:0], w_issue};
         r_done <= 1'b0;
         if (r_vld[READ_LATENCY]) begin
            r_acc <= w_accNext;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_count <= w_countClamped;
                  r_acc   <= '0;
                  if (w_countClamped == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ISSUE;
                     r_busy  <= 1'b1;
                     r_addr  <= '0;
                  end
               end
            end
            ISSUE: begin
               if (w_lastAddr) begin
                  r_state <= DRAIN;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (w_pipeEmpty) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ram_addr = r_addr;
   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_acc;

endmodule
